// File: rtl/mux8_sel_arbiter.sv
// Round-robin arbiter driving the 3-bit select of an 8:1 mux.
// Owner release input is named rel because "release" is a reserved word.
module mux8_sel_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic       HOLD_EN   = 1'(MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] sel_nxt;
    logic [7:0] gnt_nxt;
    logic       busy_nxt, timeout_nxt;

    logic [2:0] pick, cand;
    logic       found;
    logic       exit_rel, exit_drop, exit_hold;

    // Search last+1 .. last+8 (mod 8) so the previous owner comes last.
    always_comb begin
        pick  = last;
        found = 1'b0;
        cand  = last;
        for (int i = 1; i <= 8; i++) begin
            cand = last + 3'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign exit_rel  = rel;
    assign exit_drop = ~req[sel];
    assign exit_hold = HOLD_EN && (cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        cnt_nxt     = cnt;
        sel_nxt     = sel;
        gnt_nxt     = gnt;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 8'h01 << pick;
                    sel_nxt   = pick;
                    busy_nxt  = 1'b1;
                    last_nxt  = pick;
                    cnt_nxt   = 8'h00;
                end
            end
            GRANT: begin
                if (exit_rel || exit_drop || exit_hold) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = 8'h00;
                    busy_nxt    = 1'b0;
                    // Pulse only when the hold limit alone ended the grant.
                    timeout_nxt = exit_hold && !exit_rel && !exit_drop;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'h01;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 3'd7;
            cnt     <= 8'h00;
            sel     <= 3'd0;
            gnt     <= 8'h00;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            sel     <= sel_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule
